foc_sequencer: RTL

Control-loop sequencer for the FOC datapath. Once per PWM period, on the carrier peak, it runs the stages in a fixed order: current sampling, Clark/Park current transform, PI control, inverse Park/SVPWM modulation. It then issues a shadow-load pulse so new gate compare values take effect, and it owns gate enable, stage watchdogs, overrun accounting and fault latching.

---
 rtl/foc_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/foc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : foc_sequencer
//  Purpose  : Per-PWM-period sequencer for the FOC datapath. On the rising
//             carrier crossing of PEAK it runs current sampling, Clark/Park,
//             PI control and inverse Park/SVPWM in order. It then issues a
//             shadow-load pulse and updates gate enable. It also runs the
//             stage watchdogs, overrun accounting and fault latching.
//  Ports    : clk, rst_n (sync, active-low)
//             carrier      - signed PWM carrier (same as SVPWM input)
//             enable       - loop enable level
//             *_done       - stage completion pulses (adc/xform/ctrl/mod)
//             fault_clr    - fault clear pulse
//             *_start      - one-cycle stage start pulses
//             load         - one-cycle shadow-register load pulse
//             gate_en      - gate output enable
//             busy         - loop in progress (not IDLE, not FAULT)
//             fault        - sticky watchdog fault
//             fault_stage  - stage code captured at timeout
//             loop_cnt     - completed loops (wraps)
//             overrun_cnt  - dropped triggers (saturates at 255)
//  Revision : 1.0 - initial release
// ============================================================================
module foc_sequencer #(
    parameter logic signed [15:0] PEAK    = 16'sh7FF0,
    parameter int                 TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] carrier,
    input  logic               enable,
    input  logic               adc_done,
    input  logic               xform_done,
    input  logic               ctrl_done,
    input  logic               mod_done,
    input  logic               fault_clr,
    output logic               adc_start,
    output logic               xform_start,
    output logic               ctrl_start,
    output logic               mod_start,
    output logic               load,
    output logic               gate_en,
    output logic               busy,
    output logic               fault,
    output logic [2:0]         fault_stage,
    output logic [15:0]        loop_cnt,
    output logic [7:0]         overrun_cnt
);

    localparam int                c_wd_w   = $clog2(TIMEOUT + 1);
    localparam logic [c_wd_w-1:0] c_wd_max = c_wd_w'(TIMEOUT);

    // State codes double as the stage codes reported on fault_stage.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADC    = 3'd1,
        ST_XFORM  = 3'd2,
        ST_CTRL   = 3'd3,
        ST_MOD    = 3'd4,
        ST_COMMIT = 3'd5,
        ST_FAULT  = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic signed [15:0]  carrier_q, carrier_d;
    logic [3:0]          start_q, start_d;      // [0]=adc .. [3]=mod
    logic                load_q, load_d;
    logic                gate_en_q, gate_en_d;
    logic                busy_q, busy_d;
    logic                fault_q, fault_d;
    logic [2:0]          fault_stage_q, fault_stage_d;
    logic [15:0]         loop_cnt_q, loop_cnt_d;
    logic [7:0]          overrun_cnt_q, overrun_cnt_d;
    logic [c_wd_w-1:0]   wd_q, wd_d;

    logic w_trigger;
    logic w_stage_done;
    logic w_done_ok;
    logic w_timeout;

    // Rising crossing of PEAK, signed on both sides.
    assign w_trigger = (carrier_q < PEAK) && (carrier >= PEAK);

    always_comb begin
        w_stage_done = 1'b0;
        case (state_q)
            ST_ADC:   w_stage_done = adc_done;
            ST_XFORM: w_stage_done = xform_done;
            ST_CTRL:  w_stage_done = ctrl_done;
            ST_MOD:   w_stage_done = mod_done;
            default:  w_stage_done = 1'b0;
        endcase
    end

    // The watchdog count is zero only in the start cycle, so a done that
    // coincides with the start pulse is dropped here.
    assign w_done_ok = w_stage_done && (wd_q != '0);
    assign w_timeout = (wd_q == c_wd_max);

    always_comb begin
        state_d       = state_q;
        carrier_d     = carrier;
        load_d        = 1'b0;
        gate_en_d     = gate_en_q;
        fault_d       = fault_q;
        fault_stage_d = fault_stage_q;
        loop_cnt_d    = loop_cnt_q;
        overrun_cnt_d = overrun_cnt_q;
        wd_d          = '0;

        // busy_q is low in FAULT, so triggers there are never counted.
        if (w_trigger && enable && busy_q && (overrun_cnt_q != 8'hFF)) begin
            overrun_cnt_d = overrun_cnt_q + 8'd1;
        end

        if (state_q == ST_FAULT) begin
            if (fault_clr) begin
                state_d = ST_IDLE;
                fault_d = 1'b0;
            end
        end else if (!enable) begin
            state_d   = ST_IDLE;
            gate_en_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_trigger) begin
                        state_d = ST_ADC;
                    end
                end
                ST_ADC, ST_XFORM, ST_CTRL, ST_MOD: begin
                    wd_d = wd_q + 1'b1;
                    // Done is checked before the timeout so that a done
                    // arriving on the final count still advances the loop.
                    if (w_done_ok) begin
                        wd_d = '0;
                        case (state_q)
                            ST_ADC:   state_d = ST_XFORM;
                            ST_XFORM: state_d = ST_CTRL;
                            ST_CTRL:  state_d = ST_MOD;
                            default: begin
                                state_d    = ST_COMMIT;
                                load_d     = 1'b1;
                                loop_cnt_d = loop_cnt_q + 16'd1;
                                gate_en_d  = 1'b1;
                            end
                        endcase
                    end else if (w_timeout) begin
                        state_d       = ST_FAULT;
                        fault_d       = 1'b1;
                        fault_stage_d = state_q;
                        gate_en_d     = 1'b0;
                    end
                end
                ST_COMMIT: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end

        // A stage is only ever entered from a different state, so a start
        // pulse is simply "next state is this stage and differs from now".
        start_d[0] = (state_d == ST_ADC)   && (state_q != ST_ADC);
        start_d[1] = (state_d == ST_XFORM) && (state_q != ST_XFORM);
        start_d[2] = (state_d == ST_CTRL)  && (state_q != ST_CTRL);
        start_d[3] = (state_d == ST_MOD)   && (state_q != ST_MOD);

        busy_d = (state_d != ST_IDLE) && (state_d != ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            carrier_q     <= 16'sh7FFF;
            start_q       <= '0;
            load_q        <= 1'b0;
            gate_en_q     <= 1'b0;
            busy_q        <= 1'b0;
            fault_q       <= 1'b0;
            fault_stage_q <= '0;
            loop_cnt_q    <= '0;
            overrun_cnt_q <= '0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            carrier_q     <= carrier_d;
            start_q       <= start_d;
            load_q        <= load_d;
            gate_en_q     <= gate_en_d;
            busy_q        <= busy_d;
            fault_q       <= fault_d;
            fault_stage_q <= fault_stage_d;
            loop_cnt_q    <= loop_cnt_d;
            overrun_cnt_q <= overrun_cnt_d;
            wd_q          <= wd_d;
        end
    end

    assign adc_start   = start_q[0];
    assign xform_start = start_q[1];
    assign ctrl_start  = start_q[2];
    assign mod_start   = start_q[3];
    assign load        = load_q;
    assign gate_en     = gate_en_q;
    assign busy        = busy_q;
    assign fault       = fault_q;
    assign fault_stage = fault_stage_q;
    assign loop_cnt    = loop_cnt_q;
    assign overrun_cnt = overrun_cnt_q;

endmodule
`default_nettype wire
